// File: rtl/morse_tx_sequencer.sv
// Queues Morse letter/word-gap events as character-ROM addresses and feeds the
// looked-up bytes to the UART one at a time, holding each byte while tx_full is high.
module morse_tx_sequencer #(
    parameter int          DEPTH      = 4,
    parameter logic [7:0]  SPACE_ADDR = 8'hE0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      lg,
    input  logic                      wg,
    input  logic [4:0]                symbol,
    input  logic [2:0]                symbol_count,
    output logic [7:0]                rom_addr,
    input  logic [7:0]                rom_data,
    input  logic                      tx_full,
    output logic [7:0]                w_data,
    output logic                      wr_uart,
    output logic [$clog2(DEPTH):0]    pending,
    output logic                      busy,
    output logic                      overflow,
    output logic                      bad_code
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, SEND} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   wr_ptr_nxt;
    logic [PW-1:0]   count_q, count_d;
    logic [7:0]      w_data_q, w_data_d;
    logic            overflow_q, overflow_d;
    logic            bad_code_q, bad_code_d;

    logic            has_letter;
    logic [1:0]      n_push;
    logic [PW-1:0]   free_slots;
    logic            pop;
    logic            admit;
    logic            push;
    logic            push_two;
    logic [7:0]      first_entry;

    // Enqueue: a word gap may need two slots; an event is admitted whole or not at all.
    always_comb begin
        has_letter = (symbol_count != 3'd0);
        n_push     = 2'd0;
        if (wg) begin
            n_push = has_letter ? 2'd2 : 2'd1;
        end else if (lg && has_letter) begin
            n_push = 2'd1;
        end
        pop         = (state_q == LATCH);
        free_slots  = PW'(DEPTH) - count_q + PW'(pop);
        admit       = (PW'(n_push) <= free_slots);
        push        = admit && (n_push != 2'd0);
        push_two    = push && (n_push == 2'd2);
        first_entry = (wg && !has_letter) ? SPACE_ADDR : {symbol_count, symbol};
        wr_ptr_nxt  = wr_ptr_q + AW'(1);
        wr_ptr_d    = push ? (wr_ptr_q + AW'(n_push)) : wr_ptr_q;
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q - PW'(pop) + (push ? PW'(n_push) : PW'(0));
        overflow_d  = overflow_q | ((n_push != 2'd0) && !admit);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= first_entry;
        end
        if (push_two) begin
            mem[wr_ptr_nxt] <= SPACE_ADDR;
        end
    end

    always_comb begin
        state_d    = state_q;
        w_data_d   = w_data_q;
        bad_code_d = 1'b0;
        wr_uart    = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != PW'(0)) state_d = FETCH;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                w_data_d = rom_data;
                if (rom_data == 8'h00) begin
                    bad_code_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = SEND;
                end
            end
            SEND: begin
                wr_uart = ~tx_full;
                if (!tx_full) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            w_data_q   <= 8'h00;
            overflow_q <= 1'b0;
            bad_code_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            w_data_q   <= w_data_d;
            overflow_q <= overflow_d;
            bad_code_q <= bad_code_d;
        end
    end

    assign rom_addr = (count_q != PW'(0)) ? mem[rd_ptr_q] : 8'h00;
    assign w_data   = w_data_q;
    assign pending  = count_q;
    assign busy     = (state_q != IDLE) || (count_q != PW'(0));
    assign overflow = overflow_q;
    assign bad_code = bad_code_q;

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Directed bench for morse_tx_sequencer: a queue-based reference model checked every
// cycle, plus literal expectations on strobe data, latency and counts.
module tb_morse_tx_sequencer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lg = 1'b0;
    logic       wg = 1'b0;
    logic [4:0] symbol = 5'd0;
    logic [2:0] symbol_count = 3'd0;
    logic [7:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic       tx_full = 1'b0;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [2:0] pending;
    logic       busy;
    logic       overflow;
    logic       bad_code;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int bad_cnt = 0;
    logic [7:0] wlog[$];
    int         wcyc[$];

    morse_tx_sequencer #(.DEPTH(DEPTH), .SPACE_ADDR(8'hE0)) dut (
        .clk(clk), .reset_n(reset_n), .lg(lg), .wg(wg), .symbol(symbol),
        .symbol_count(symbol_count), .rom_addr(rom_addr), .rom_data(rom_data),
        .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .pending(pending),
        .busy(busy), .overflow(overflow), .bad_code(bad_code)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [7:0] a);
        case (a)
            8'h42:   return 8'h41;
            8'hE0:   return 8'h20;
            8'h4A:   return 8'h00;
            default: return a + 8'h01;
        endcase
    endfunction

    // Synchronous character ROM in the environment.
    always @(posedge clk) rom_data <= rom(rom_addr);

    always @(posedge clk) cyc++;

    // Reference model: FIFO of ROM addresses; each entry is serviced over a
    // fixed sequence of cycles (notice, address out, data back, hand to UART).
    logic [7:0] mq[$];
    int         svc_step = 0;
    logic [7:0] wd_m = 8'h00;
    bit         ovf_m = 1'b0;
    bit         bad_m = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            svc_step = 0;
            wd_m = 8'h00;
            ovf_m = 1'b0;
            bad_m = 1'b0;
        end else begin
            int n;
            logic [7:0] got;
            bad_m = 1'b0;
            case (svc_step)
                0: if (mq.size() != 0) svc_step = 1;
                1: svc_step = 2;
                2: begin
                    got = rom(mq[0]);
                    wd_m = got;
                    void'(mq.pop_front());
                    bad_m = (got == 8'h00);
                    svc_step = bad_m ? 0 : 3;
                end
                default: if (!tx_full) svc_step = 0;
            endcase
            if (wg) n = (symbol_count != 0) ? 2 : 1;
            else if (lg && symbol_count != 0) n = 1;
            else n = 0;
            if (n > 0) begin
                if (mq.size() + n <= DEPTH) begin
                    if (symbol_count != 0) mq.push_back({symbol_count, symbol});
                    if (wg) mq.push_back(8'hE0);
                end else begin
                    ovf_m = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e_addr;
        logic       e_wr;
        e_addr = (mq.size() != 0) ? mq[0] : 8'h00;
        e_wr   = (svc_step == 3) && !tx_full;
        vectors++;
        if (wr_uart !== e_wr || w_data !== wd_m || pending !== 3'(mq.size()) ||
            busy !== ((svc_step != 0) || (mq.size() != 0)) || overflow !== ovf_m ||
            bad_code !== bad_m || rom_addr !== e_addr) begin
            miscompares++;
            $display("FAIL cycle_model cyc=%0d got wr=%0b wd=%h pend=%0d busy=%0b ovf=%0b bad=%0b addr=%h required wr=%0b wd=%h pend=%0d ovf=%0b bad=%0b addr=%h",
                     cyc, wr_uart, w_data, pending, busy, overflow, bad_code, rom_addr,
                     e_wr, wd_m, mq.size(), ovf_m, bad_m, e_addr);
        end
        if (wr_uart === 1'b1) begin
            wlog.push_back(w_data);
            wcyc.push_back(cyc);
            $display("write cyc=%0d w_data=%h", cyc, w_data);
        end
        if (bad_code === 1'b1) bad_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit l, input bit w, input logic [2:0] cnt, input logic [4:0] sym);
        lg = l; wg = w; symbol_count = cnt; symbol = sym;
        tick();
        lg = 1'b0; wg = 1'b0; symbol_count = 3'd0; symbol = 5'd0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check({name, "_idle_timeout"}, busy, 0);
        tick();
    endtask

    int ev;
    int rel;

    initial begin
        #200000;
        $display("FAIL watchdog got no_finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("rst_wr", wr_uart, 0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_wdata", w_data, 0);
        check("rst_bad", bad_code, 0);
        reset_n = 1'b1;
        tick();

        // Single letter, latency 4.
        wlog.delete(); wcyc.delete();
        ev = cyc;
        pulse(1, 0, 3'd2, 5'b00010);
        wait_idle("t1", 40);
        check("t1_count", wlog.size(), 1);
        if (wlog.size() >= 1) begin
            check("t1_data", wlog[0], 8'h41);
            check("t1_latency", wcyc[0] - ev, 4);
        end
        check("t1_busy", busy, 0);

        // lg with zero elements is ignored.
        pulse(1, 0, 3'd0, 5'b00000);
        check("t1b_pending", pending, 0);
        check("t1b_busy", busy, 0);

        // Word gap: letter then space at +4 and +8.
        wlog.delete(); wcyc.delete();
        ev = cyc;
        pulse(0, 1, 3'd2, 5'b00010);
        wait_idle("t2", 60);
        check("t2_count", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            check("t2_data0", wlog[0], 8'h41);
            check("t2_data1", wlog[1], 8'h20);
            check("t2_lat0", wcyc[0] - ev, 4);
            check("t2_lat1", wcyc[1] - ev, 8);
        end
        wlog.delete(); wcyc.delete();
        pulse(0, 1, 3'd0, 5'b00000);
        wait_idle("t2b", 40);
        check("t2b_count", wlog.size(), 1);
        if (wlog.size() >= 1) check("t2b_data", wlog[0], 8'h20);

        // lg and wg together behave as wg.
        wlog.delete(); wcyc.delete();
        pulse(1, 1, 3'd2, 5'b00010);
        wait_idle("t2c", 60);
        check("t2c_count", wlog.size(), 2);

        // Backpressure for 10 cycles.
        wlog.delete(); wcyc.delete();
        tx_full = 1'b1;
        pulse(1, 0, 3'd2, 5'b00010);
        repeat (9) tick();
        check("t3_no_write", wlog.size(), 0);
        check("t3_wdata_hold", w_data, 8'h41);
        tx_full = 1'b0;
        rel = cyc;
        wait_idle("t3", 40);
        check("t3_count", wlog.size(), 1);
        if (wlog.size() >= 1) check("t3_when", wcyc[0], rel);

        // Overflow with a full queue.
        wlog.delete(); wcyc.delete();
        tx_full = 1'b1;
        pulse(0, 1, 3'd2, 5'b00010);
        pulse(0, 1, 3'd2, 5'b00010);
        pulse(0, 1, 3'd2, 5'b00010);
        check("t4_pending", pending, 4);
        check("t4_overflow", overflow, 1);
        repeat (5) tick();
        tx_full = 1'b0;
        wait_idle("t4", 100);
        check("t4_count", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            check($sformatf("t4_data%0d", i), wlog[i], (i % 2 == 0) ? 8'h41 : 8'h20);
        check("t4_ovf_sticky", overflow, 1);

        // Bad code followed by a good entry.
        wlog.delete(); wcyc.delete();
        bad_cnt = 0;
        pulse(1, 0, 3'd2, 5'b01010);
        pulse(1, 0, 3'd2, 5'b00010);
        wait_idle("t5", 60);
        check("t5_bad_pulses", bad_cnt, 1);
        check("t5_count", wlog.size(), 1);
        if (wlog.size() >= 1) check("t5_data", wlog[0], 8'h41);

        // Reset during SEND with entries pending.
        wlog.delete(); wcyc.delete();
        tx_full = 1'b1;
        pulse(0, 1, 3'd2, 5'b00010);
        pulse(1, 0, 3'd2, 5'b00010);
        repeat (3) tick();
        check("t6_pending_pre", pending, 2);
        reset_n = 1'b0;
        #1;
        check("t6_wr", wr_uart, 0);
        check("t6_pending", pending, 0);
        check("t6_busy", busy, 0);
        check("t6_ovf", overflow, 0);
        check("t6_wdata", w_data, 0);
        check("t6_bad", bad_code, 0);
        tick();
        reset_n = 1'b1;
        tx_full = 1'b0;
        repeat (12) tick();
        check("t6_no_write", wlog.size(), 0);
        check("t6_busy_after", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/morse_tx_sequencer.md
# morse_tx_sequencer

Sequences decoded Morse characters into the UART transmitter. It captures each letter-gap and word-gap event from the decoder/shift-register path, queues the matching ROM addresses, and drives the synchronous character ROM. It then writes each looked-up byte to the UART exactly once, honouring `tx_full` backpressure. It replaces the direct `lg | wg`-driven `wr_uart` path, so no character or space is lost or duplicated while the UART FIFO is full.

## Interface
- `DEPTH`, 4: address-queue entries, power of two, ≥2.
- `SPACE_ADDR`, 8'hE0: ROM address of the space character.
- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `lg`  in  1  letter-gap pulse from the Morse decoder, 1 cycle.
- `wg`  in  1  word-gap pulse from the Morse decoder, 1 cycle.
- `symbol`  in  5  current dot/dash pattern (dash=1); valid in the `lg`/`wg` cycle.
- `symbol_count`  in  3  number of elements in `symbol`, 0..5.
- `rom_addr`  out  8  address to the synchronous ROM; the ROM registers it on `clk`.
- `rom_data`  in  8  ROM output, valid one cycle after the address is presented.
- `tx_full`  in  1  UART TX FIFO full.
- `w_data`  out  8  byte to the UART.
- `wr_uart`  out  1  UART write strobe, 1 cycle per byte.
- `pending`  out  $clog2(DEPTH)+1  queue occupancy.
- `busy`  out  1  high when the queue is non-empty or the state is not IDLE.
- `overflow`  out  1  sticky; set when an event is dropped. Cleared only by reset.
- `bad_code`  out  1  1-cycle pulse when the ROM returns 8'h00.

## Operation
- Enqueue rules are evaluated in the event cycle and written at its closing edge.
  - `lg` with `symbol_count`>0: push `{symbol_count, symbol}`.
  - `lg` with `symbol_count`==0: ignored.
  - `wg`: push `{symbol_count, symbol}` when `symbol_count`>0, then push `SPACE_ADDR`. Both entries are written in the same edge.
  - `lg` and `wg` in the same cycle: treated as `wg` alone.
- Event admission:
  - An event is admitted only if its whole entry set fits in the free space.
  - Otherwise the whole event is dropped (no partial word) and `overflow` is set.
  - A push is allowed in the same cycle as a pop; free space counts the pop.
- Queue: circular FIFO with read/write pointers. Pointers wrap modulo `DEPTH`.
- `rom_addr` is combinational from the queue head; it is 8'h00 when the queue is empty.
- The FSM has four states:
  - IDLE: if the queue is non-empty, go to FETCH.
  - FETCH: `rom_addr` = head and the ROM samples it at this edge. Go to LATCH.
  - LATCH: capture `rom_data` into the `w_data` register and pop the head.
    - If `rom_data`==8'h00, pulse `bad_code` and go to IDLE; no write occurs.
    - Otherwise go to SEND.
  - SEND: `wr_uart` = ~`tx_full`, combinational. When `tx_full`==0, go to IDLE; else stay in SEND.
- `w_data` is stable from LATCH exit until the next LATCH.
- `busy` = (state≠IDLE) | (`pending`≠0).
- Reset values: state IDLE, queue empty, `pending` 0, `w_data` 8'h00, `wr_uart` 0, `busy` 0, `overflow` 0, `bad_code` 0.
- Reset asserted mid-operation: all state and outputs clear immediately. Any byte in flight is abandoned and never written.

## Timing
- Empty queue, `tx_full`=0: an event at cycle 0 is enqueued at edge 0.
  - Cycle 1: IDLE. Cycle 2: FETCH. Cycle 3: LATCH. Cycle 4: SEND with `wr_uart`=1.
  - Latency is 4 cycles from event to strobe.
- Throughput is one byte per 4 cycles. A word gap yields its letter strobe at cycle 4 and the space strobe at cycle 8.
- `pending` decrements at the LATCH edge.
- `tx_full` handling:
  - `tx_full` high in SEND holds the FSM with `wr_uart`=0.
  - `wr_uart` rises in the first cycle `tx_full` is low.
  - No more than one strobe is issued per queue entry.
- `overflow` rises at the edge closing the dropped-event cycle.
- `bad_code` is high during the cycle after LATCH, i.e. it is registered.

## Test plan
- Letter, ROM model returns 8'h41 at addr 8'h42: `lg`, `symbol_count`=2, `symbol`=5'b00010 → `wr_uart` pulses once, 4 cycles after `lg`, with `w_data`=8'h41; `busy` then returns to 0.
- Word gap, `symbol_count`=2, `symbol`=5'b00010: `wg` → two strobes at cycles 4 and 8 carrying 8'h41 then 8'h20 (addr 8'hE0); a second `wg` with `symbol_count`=0 → a single 8'h20.
- Backpressure: `tx_full`=1 for 10 cycles starting before SEND → `wr_uart` stays 0 and `w_data` holds. Exactly one strobe occurs in the first cycle after `tx_full` falls.
- Overflow, `DEPTH`=4, `tx_full`=1: three `wg` events with `symbol_count`=2 → `pending`=4 and `overflow`=1 after the third. Release `tx_full` → exactly 4 bytes are written: letter, space, letter, space.
- Bad code: ROM returns 8'h00 → `bad_code` pulses 1 cycle, no `wr_uart`, and the next queued entry is processed normally.
- Reset: assert `reset_n`=0 during SEND with 2 entries pending → all outputs are 0 and `pending`=0 immediately. After release there is no strobe until a new event.
